invaders_grid: RTL
==================

INVADERS_GRID -- requirements
Module: invaders_grid

Interface
REQ-001 Parameter COLS, default 20, invader columns per row (>=4).
REQ-002 Parameter ROWS, default 3, invader rows in formation (1..4).
REQ-003 Parameter INIT_WIDTH, default 9, invaders per row at reset (<=COLS), occupying bits [INIT_WIDTH-1:0].
REQ-004 Parameter LAST_ROW, default 14, field row at which the formation has landed.
REQ-005 Parameter BASE_PERIOD, default 100000, clocks per step with the full formation alive; MIN_PERIOD, default 20000, floor; STEP_DEC, default 2500, period decrement per killed invader.
REQ-006 i_clk_36MHz input 1: clock; all state on its rising edge.
REQ-007 i_reset input 1: reset, synchronous, active-high.
REQ-008 i_bullet_valid input 1: i_bullet_x/i_bullet_y are valid this cycle.
REQ-009 i_bullet_x input CW=$clog2(COLS): bullet column. i_bullet_y input 4: bullet field row.
REQ-010 o_hit output 1: one-cycle hit pulse. o_hit_row output 2: formation row index of the hit.
REQ-011 o_invaders_array output ROWS*COLS: row r occupies bits [r*COLS+COLS-1 : r*COLS], 1 = alive.
REQ-012 o_top_row output 4: field row of formation row 0; row r sits at o_top_row+r.
REQ-013 o_alive_count output $clog2(ROWS*COLS+1): count of set bits in o_invaders_array.
REQ-014 o_landed output 1, o_cleared output 1: sticky game-end flags.

Function
REQ-015 States: MARCH, LANDED, CLEARED; only MARCH changes the array or o_top_row.
REQ-016 Hit: in MARCH, i_bullet_valid and i_bullet_y==o_top_row+r and i_bullet_x<COLS and bit set -> next cycle bit cleared, o_hit=1, o_hit_row=r, o_alive_count decremented by 1.
REQ-017 Bullet on an empty cell, i_bullet_x>=COLS, or y outside rows -> no hit, no change.
REQ-018 Step tick from the sub-timer; tick coinciding with a hit is held pending and executed on the next cycle without a hit; at most one pending step.
REQ-019 Direction LEFT shifts every row toward higher index by 1; RIGHT toward lower index by 1.
REQ-020 Edge: LEFT with any row's bit COLS-1 set, or RIGHT with any row's bit 0 set -> no shift, o_top_row+1, direction flips; same step.
REQ-021 Empty rows excluded from edge test; all rows shift together.
REQ-022 Landed: after a descend, if (o_top_row + index of lowest non-empty row) >= LAST_ROW -> state LANDED, o_landed=1.
REQ-023 o_alive_count reaching 0 -> state CLEARED, o_cleared=1 next cycle; takes priority over a same-cycle pending step.
REQ-024 LANDED/CLEARED: all outputs frozen, bullets ignored, o_hit=0, until reset.
REQ-025 o_hit is 0 on every cycle without a hit; never high two consecutive cycles for one bullet cell.
REQ-026 Arithmetic: o_top_row saturates at 15; period computation uses a 20-bit unsigned width, no wrap.

Reset
REQ-027 i_reset: each row = INIT_WIDTH low bits set, o_top_row=1, direction LEFT, MARCH, o_hit=0, o_hit_row=0, o_alive_count=ROWS*INIT_WIDTH, flags 0, pending step cleared, timer count 0.
REQ-028 Reset mid-step or mid-hit wins; no hit or step from that cycle is applied.
REQ-029 Initial values equal reset values (power-up without reset).

Configuration
REQ-030 INVADERS_SPEEDUP_EN defined: period = max(MIN_PERIOD, BASE_PERIOD - STEP_DEC*(ROWS*INIT_WIDTH - o_alive_count)).
REQ-031 INVADERS_SPEEDUP_EN undefined: period fixed at BASE_PERIOD.
REQ-032 Period shrinking below the current count: tick fires the next cycle and the count restarts at 0.

Structure
REQ-033 Package invaders_pkg: direction constants LEFT=0/RIGHT=1, state enum {MARCH, LANDED, CLEARED}, default period constants.
REQ-034 Sub-module invaders_step_timer: 20-bit period input, one-cycle tick output every period clocks, synchronous reset.

Verification (COLS=8, ROWS=2, INIT_WIDTH=3, BASE_PERIOD=4, MIN_PERIOD=2, STEP_DEC=1, LAST_ROW=6)
REQ-035 Reset -> array 16'h0707, o_top_row=1, o_alive_count=6; 4 clocks later array 16'h0E0E.
REQ-036 Valid bullet x=1,y=2 at reset state -> o_hit=1 one cycle, o_hit_row=1, array 16'h0507, count 5; bullet repeated -> no hit.
REQ-037 Run until bit 7 set (array 16'hE0E0) -> next tick o_top_row=2, array unchanged, direction RIGHT.
REQ-038 Tick and hit in same cycle -> hit applied, shift one cycle later.
REQ-039 Kill all 6 -> o_cleared=1, state frozen; descend to top row 5 with row 1 occupied -> o_landed=1, outputs frozen, bullets ignored.
REQ-040 With INVADERS_SPEEDUP_EN, after 2 kills, ticks spaced 2 clocks; without it, 4 clocks.

Source files
------------

// File: rtl/invaders_pkg.sv
// Shared constants and types for the invaders formation grid.
package invaders_pkg;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic [1:0] {
        MARCH,
        LANDED,
        CLEARED
    } state_t;

    localparam int PERIOD_W            = 20;
    localparam int DEFAULT_BASE_PERIOD = 100000;
    localparam int DEFAULT_MIN_PERIOD  = 20000;
    localparam int DEFAULT_STEP_DEC    = 2500;

    // Step period after 'killed' invaders are gone, floored at floor_p; wide math so nothing wraps.
    function automatic logic [PERIOD_W-1:0] calc_period(
        input int unsigned base,
        input int unsigned floor_p,
        input int unsigned dec,
        input int unsigned killed
    );
        longint unsigned cut;
        cut = 64'(dec) * 64'(killed);
        if (cut + 64'(floor_p) >= 64'(base)) return PERIOD_W'(floor_p);
        return PERIOD_W'(64'(base) - cut);
    endfunction

endpackage

// File: rtl/invaders_grid_if.sv
// Bullet input and formation status bundle between the game core and the grid.
interface invaders_grid_if #(
    parameter int COLS = 20,
    parameter int ROWS = 3
);
    localparam int CW = $clog2(COLS);
    localparam int AW = $clog2(ROWS*COLS+1);

    logic                 i_bullet_valid;
    logic [CW-1:0]        i_bullet_x;
    logic [3:0]           i_bullet_y;
    logic                 o_hit;
    logic [1:0]           o_hit_row;
    logic [ROWS*COLS-1:0] o_invaders_array;
    logic [3:0]           o_top_row;
    logic [AW-1:0]        o_alive_count;
    logic                 o_landed;
    logic                 o_cleared;

    modport master (
        output i_bullet_valid, i_bullet_x, i_bullet_y,
        input  o_hit, o_hit_row, o_invaders_array, o_top_row, o_alive_count, o_landed, o_cleared
    );

    modport slave (
        input  i_bullet_valid, i_bullet_x, i_bullet_y,
        output o_hit, o_hit_row, o_invaders_array, o_top_row, o_alive_count, o_landed, o_cleared
    );

endinterface

// File: rtl/invaders_step_timer.sv
// Free-running step timer: one-cycle tick every i_period clocks.
module invaders_step_timer
    import invaders_pkg::*;
(
    input  logic                i_clk_36MHz,
    input  logic                i_reset,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_tick
);

    logic [PERIOD_W-1:0] count_q = '0;

    // >= so a period that shrinks below the running count fires straight away
    assign o_tick = ({1'b0, count_q} + 21'd1) >= {1'b0, i_period};

    always_ff @(posedge i_clk_36MHz) begin
        if (i_reset || o_tick) count_q <= '0;
        else                   count_q <= count_q + 1'b1;
    end

endmodule

// File: rtl/invaders_grid.sv
// Invader formation: hit detection, marching, descent and game-end flags.
// Define INVADERS_SPEEDUP_EN to shorten the step period as invaders are killed.
module invaders_grid
    import invaders_pkg::*;
#(
    parameter int COLS        = 20,
    parameter int ROWS        = 3,
    parameter int INIT_WIDTH  = 9,
    parameter int LAST_ROW    = 14,
    parameter int BASE_PERIOD = DEFAULT_BASE_PERIOD,
    parameter int MIN_PERIOD  = DEFAULT_MIN_PERIOD,
    parameter int STEP_DEC    = DEFAULT_STEP_DEC
) (
    input  logic           i_clk_36MHz,
    input  logic           i_reset,
    invaders_grid_if.slave bus
);

    localparam int AW         = $clog2(ROWS*COLS+1);
    localparam int INIT_ALIVE = ROWS*INIT_WIDTH;
    localparam logic [COLS-1:0] INIT_ROW = COLS'((64'd1 << INIT_WIDTH) - 64'd1);

    if (COLS < 4 || ROWS < 1 || ROWS > 4 || INIT_WIDTH > COLS ||
        MIN_PERIOD > BASE_PERIOD || STEP_DEC < 0) begin : g_bad_cfg
        $error("invaders_grid: unsupported parameter set");
    end

    logic [ROWS-1:0][COLS-1:0] grid_q = {ROWS{INIT_ROW}};
    logic [3:0]                top_q = 4'd1;
    logic                      dir_q = LEFT;
    state_t                    state_q = MARCH;
    logic                      pend_q = 1'b0;
    logic                      hit_q = 1'b0;
    logic [1:0]                hit_row_q = 2'd0;
    logic [AW-1:0]             alive_q = AW'(INIT_ALIVE);
    logic                      landed_q = 1'b0;
    logic                      cleared_q = 1'b0;

    logic [ROWS-1:0][COLS-1:0] grid_d;
    logic [3:0]                top_d;
    logic                      dir_d;
    state_t                    state_d;
    logic                      pend_d;
    logic                      hit_d;
    logic [1:0]                hit_row_d;
    logic [AW-1:0]             alive_d;
    logic                      landed_d;
    logic                      cleared_d;

    logic [PERIOD_W-1:0]       period;
    logic                      tick;
    logic                      bullet_ok;
    logic [ROWS-1:0]           row_hit;
    logic                      at_edge;
    int                        low_idx;
    int                        land_row;

`ifdef INVADERS_SPEEDUP_EN
    assign period = calc_period(BASE_PERIOD, MIN_PERIOD, STEP_DEC, INIT_ALIVE - int'(alive_q));
`else
    assign period = PERIOD_W'(BASE_PERIOD);
`endif

    invaders_step_timer u_timer (
        .i_clk_36MHz (i_clk_36MHz),
        .i_reset     (i_reset),
        .i_period    (period),
        .o_tick      (tick)
    );

    assign bullet_ok = bus.i_bullet_valid && (int'(bus.i_bullet_x) < COLS);

    // Five-bit compare so rows below field row 15 never alias onto the top rows
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign row_hit[r] = bullet_ok && ({1'b0, bus.i_bullet_y} == {1'b0, top_q} + 5'(r)) &&
                            grid_q[r][bus.i_bullet_x];
    end

    always_comb begin
        at_edge = 1'b0;
        for (int r = 0; r < ROWS; r++)
            at_edge |= (dir_q == LEFT) ? grid_q[r][COLS-1] : grid_q[r][0];
    end

    always_comb begin
        grid_d    = grid_q;
        top_d     = top_q;
        dir_d     = dir_q;
        state_d   = state_q;
        pend_d    = pend_q;
        hit_d     = 1'b0;
        hit_row_d = hit_row_q;
        alive_d   = alive_q;
        landed_d  = landed_q;
        cleared_d = cleared_q;
        low_idx   = 0;
        land_row  = 0;
        for (int r = 0; r < ROWS; r++)
            if (|grid_q[r]) low_idx = r;

        case (state_q)
            MARCH: begin
                if (alive_q == '0) begin
                    state_d   = CLEARED;
                    cleared_d = 1'b1;
                    pend_d    = 1'b0;
                end else if (|row_hit) begin
                    // A tick landing on a hit cycle waits one cycle instead of being lost
                    hit_d   = 1'b1;
                    alive_d = alive_q - AW'(1);
                    pend_d  = pend_q | tick;
                    for (int r = 0; r < ROWS; r++) begin
                        if (row_hit[r]) begin
                            grid_d[r][bus.i_bullet_x] = 1'b0;
                            hit_row_d = 2'(r);
                        end
                    end
                end else if (tick || pend_q) begin
                    pend_d = 1'b0;
                    if (at_edge) begin
                        top_d    = (top_q == 4'hF) ? top_q : top_q + 4'd1;
                        dir_d    = ~dir_q;
                        land_row = int'(top_d) + low_idx;
                        if (land_row >= LAST_ROW) begin
                            state_d  = LANDED;
                            landed_d = 1'b1;
                        end
                    end else begin
                        for (int r = 0; r < ROWS; r++)
                            grid_d[r] = (dir_q == LEFT) ? (grid_q[r] << 1) : (grid_q[r] >> 1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk_36MHz) begin
        if (i_reset) begin
            grid_q    <= {ROWS{INIT_ROW}};
            top_q     <= 4'd1;
            dir_q     <= LEFT;
            state_q   <= MARCH;
            pend_q    <= 1'b0;
            hit_q     <= 1'b0;
            hit_row_q <= 2'd0;
            alive_q   <= AW'(INIT_ALIVE);
            landed_q  <= 1'b0;
            cleared_q <= 1'b0;
        end else begin
            grid_q    <= grid_d;
            top_q     <= top_d;
            dir_q     <= dir_d;
            state_q   <= state_d;
            pend_q    <= pend_d;
            hit_q     <= hit_d;
            hit_row_q <= hit_row_d;
            alive_q   <= alive_d;
            landed_q  <= landed_d;
            cleared_q <= cleared_d;
        end
    end

    assign bus.o_invaders_array = grid_q;
    assign bus.o_top_row        = top_q;
    assign bus.o_alive_count    = alive_q;
    assign bus.o_hit            = hit_q;
    assign bus.o_hit_row        = hit_row_q;
    assign bus.o_landed         = landed_q;
    assign bus.o_cleared        = cleared_q;

endmodule
